// File: rtl/pic_seq_pkg.sv
`default_nettype none
// ============================================================================
// pic_seq_pkg : shared types and ICW/OCW constants for the PIC init sequencer
// Revision    : 1.0
// ============================================================================
package pic_seq_pkg;

    typedef enum logic [2:0] {
        STEP_ICW1 = 3'd0,
        STEP_ICW2 = 3'd1,
        STEP_ICW3 = 3'd2,
        STEP_ICW4 = 3'd3,
        STEP_OCW1 = 3'd4,
        STEP_RDBK = 3'd5
    } step_t;

    typedef enum logic [2:0] {
        BUS_IDLE   = 3'd0,
        BUS_SETUP  = 3'd1,
        BUS_STROBE = 3'd2,
        BUS_HOLD   = 3'd3,
        BUS_GAP    = 3'd4
    } bus_state_t;

    localparam logic [7:0] ICW1_VAL      = 8'h11;
    // SNGL bit set: a lone master has no ICW3
    localparam logic [7:0] ICW1_SNGL_VAL = 8'h13;
    localparam logic [7:0] ICW4_MASTER   = 8'h00;
    localparam logic [7:0] ICW4_SLAVE    = 8'h02;
    localparam logic [7:0] OCW1_VAL      = 8'h00;

    function automatic step_t step_after(input step_t s);
        step_t r;
        case (s)
            STEP_ICW1: r = STEP_ICW2;
            STEP_ICW2: r = STEP_ICW3;
            STEP_ICW3: r = STEP_ICW4;
            STEP_ICW4: r = STEP_OCW1;
            STEP_OCW1: r = STEP_RDBK;
            default:   r = STEP_ICW1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_init_table.sv
`default_nettype none
// ============================================================================
// pic_init_table : (pic index, step) -> {data, a0, skip} for the init sequence
// Option         : PIC_INIT_READBACK_EN enables the readback step
// Revision       : 1.0
// ============================================================================
module pic_init_table
    import pic_seq_pkg::*;
#(
    parameter int         NUM_PICS    = 7,
    parameter logic [7:0] VECTOR_BASE = 8'h08
) (
    input  logic [2:0] pic_idx,
    input  step_t      step,
    output logic [7:0] data,
    output logic       a0,
    output logic       skip
);

    localparam int         c_mask_i      = (1 << (NUM_PICS - 1)) - 1;
    localparam logic [7:0] c_master_mask = c_mask_i[7:0];

    always_comb begin
        data = 8'h00;
        a0   = 1'b1;
        skip = 1'b0;
        case (step)
            STEP_ICW1: begin
                a0   = 1'b0;
                data = (NUM_PICS == 1) ? ICW1_SNGL_VAL : ICW1_VAL;
            end
            STEP_ICW2: data = VECTOR_BASE + {2'b00, pic_idx, 3'b000};
            STEP_ICW3: begin
                // master: one bit per attached slave; slave: its cascade ID
                data = (pic_idx == 3'd0) ? c_master_mask : {5'b00000, pic_idx - 3'd1};
                skip = (NUM_PICS == 1);
            end
            STEP_ICW4: data = (pic_idx == 3'd0) ? ICW4_MASTER : ICW4_SLAVE;
            STEP_OCW1: data = OCW1_VAL;
            STEP_RDBK: begin
`ifdef PIC_INIT_READBACK_EN
                skip = 1'b0;
`else
                skip = 1'b1;
`endif
            end
            default:   skip = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pic_cascade_init_sequencer.sv
`default_nettype none
// ============================================================================
// pic_cascade_init_sequencer : programs a master 8259 plus cascaded slaves,
//                              then forwards single runtime OCW writes
// Option                     : PIC_INIT_READBACK_EN adds a readback cycle per PIC
// Revision                   : 1.0
// ============================================================================
module pic_cascade_init_sequencer
    import pic_seq_pkg::*;
#(
    parameter int         NUM_PICS    = 7,
    parameter int         SETUP_CYC   = 1,
    parameter int         WR_LOW_CYC  = 2,
    parameter int         HOLD_CYC    = 1,
    parameter logic [7:0] VECTOR_BASE = 8'h08
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                wr_req,
    input  logic [2:0]          wr_pic,
    input  logic                wr_a0,
    input  logic [7:0]          wr_data,
    output logic                wr_ack,
    output logic                wr_err,
    output logic [NUM_PICS-1:0] cs_n,
    output logic                a0,
    output logic                wr_n,
    output logic [7:0]          d_out,
    output logic                d_oe
`ifdef PIC_INIT_READBACK_EN
    ,
    output logic                rd_n,
    input  logic [7:0]          d_in,
    output logic                init_err
`endif
);

    localparam int c_cnt_max = (SETUP_CYC > WR_LOW_CYC)
                             ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                             : ((WR_LOW_CYC > HOLD_CYC) ? WR_LOW_CYC : HOLD_CYC);
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_setup_last  = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_strobe_last = c_cnt_w'(WR_LOW_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(HOLD_CYC - 1);

    bus_state_t          r_state,  w_state_d;
    logic [c_cnt_w-1:0]  r_cnt,    w_cnt_d;
    logic [2:0]          r_pic,    w_pic_d;
    step_t               r_step,   w_step_d;
    logic                r_fin,    w_fin_d;
    logic                r_busy,   w_busy_d;
    logic                r_done,   w_done_d;
    logic                r_wr_ack, w_wr_ack_d;
    logic                r_wr_err, w_wr_err_d;
    logic                r_pend,   w_pend_d;
    logic                r_rdbk,   w_rdbk_d;
    logic [NUM_PICS-1:0] r_cs_n,   w_cs_n_d;
    logic                r_a0,     w_a0_d;
    logic                r_wr_n,   w_wr_n_d;
    logic [7:0]          r_d_out,  w_d_out_d;
    logic                r_d_oe,   w_d_oe_d;
`ifdef PIC_INIT_READBACK_EN
    logic                r_rd_n,     w_rd_n_d;
    logic                r_init_err, w_init_err_d;
`endif

    logic [7:0]          w_tbl_data;
    logic                w_tbl_a0;
    logic                w_tbl_skip;
    logic                w_is_rdbk;
    logic [2:0]          w_adv_pic;
    step_t               w_adv_step;
    logic                w_adv_fin;
    logic [NUM_PICS-1:0] w_init_cs_n;
    logic [NUM_PICS-1:0] w_rt_cs_n;
    logic                w_pic_ok;
    logic                w_phase_last;
    logic                w_start_take;
    logic                w_load_init;
    logic                w_load_rt;

    // Table is addressed by the init pointer, which always names the next
    // write to launch; the bus outputs are registered, so the pointer may
    // move while a write is still on the bus.
    pic_init_table #(
        .NUM_PICS    (NUM_PICS),
        .VECTOR_BASE (VECTOR_BASE)
    ) u_table (
        .pic_idx (r_pic),
        .step    (r_step),
        .data    (w_tbl_data),
        .a0      (w_tbl_a0),
        .skip    (w_tbl_skip)
    );

    assign w_is_rdbk = (r_step == STEP_RDBK);
    assign w_pic_ok  = ({1'b0, wr_pic} < 4'(NUM_PICS));

    always_comb begin
        for (int i = 0; i < NUM_PICS; i++) begin
            w_init_cs_n[i] = (r_pic != 3'(i));
            w_rt_cs_n[i]   = (wr_pic != 3'(i));
        end
    end

    always_comb begin
        w_adv_pic  = r_pic;
        w_adv_fin  = 1'b0;
        w_adv_step = step_after(r_step);
        if (r_step == STEP_RDBK) begin
            if (r_pic == 3'(NUM_PICS - 1)) begin
                w_adv_fin = 1'b1;
            end else begin
                w_adv_pic = r_pic + 3'd1;
            end
        end
    end

    always_comb begin
        case (r_state)
            BUS_SETUP:  w_phase_last = (r_cnt == c_setup_last);
            BUS_STROBE: w_phase_last = (r_cnt == c_strobe_last);
            BUS_HOLD:   w_phase_last = (r_cnt == c_hold_last);
            default:    w_phase_last = 1'b1;
        endcase
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_pic_d      = r_pic;
        w_step_d     = r_step;
        w_fin_d      = r_fin;
        w_busy_d     = r_busy;
        w_done_d     = 1'b0;
        w_wr_ack_d   = 1'b0;
        w_wr_err_d   = 1'b0;
        w_pend_d     = r_pend;
        w_rdbk_d     = r_rdbk;
        w_cs_n_d     = r_cs_n;
        w_a0_d       = r_a0;
        w_wr_n_d     = r_wr_n;
        w_d_out_d    = r_d_out;
        w_d_oe_d     = r_d_oe;
`ifdef PIC_INIT_READBACK_EN
        w_rd_n_d     = r_rd_n;
        w_init_err_d = r_init_err;
`endif
        w_start_take = 1'b0;
        w_load_init  = 1'b0;
        w_load_rt    = 1'b0;

        case (r_state)
            BUS_IDLE: begin
                if (start && !r_busy) begin
                    w_start_take = 1'b1;
                end else if (wr_req && !r_busy && !r_wr_ack) begin
                    // r_wr_ack blocks the still-high request of the ack cycle
                    if (w_pic_ok) begin
                        w_load_rt = 1'b1;
                    end else begin
                        w_wr_ack_d = 1'b1;
                        w_wr_err_d = 1'b1;
                    end
                end
            end
            BUS_SETUP: begin
                if (w_phase_last) begin
                    w_state_d = BUS_STROBE;
                    w_cnt_d   = '0;
`ifdef PIC_INIT_READBACK_EN
                    if (r_rdbk) w_rd_n_d = 1'b0;
                    else        w_wr_n_d = 1'b0;
`else
                    w_wr_n_d  = 1'b0;
`endif
                end else begin
                    w_cnt_d = r_cnt + c_cnt_w'(1);
                end
            end
            BUS_STROBE: begin
                if (w_phase_last) begin
                    w_state_d = BUS_HOLD;
                    w_cnt_d   = '0;
                    w_wr_n_d  = 1'b1;
`ifdef PIC_INIT_READBACK_EN
                    w_rd_n_d  = 1'b1;
                    if (r_rdbk && (d_in != 8'h00)) w_init_err_d = 1'b1;
`endif
                    if (r_busy) begin
                        w_pic_d  = w_adv_pic;
                        w_step_d = w_adv_step;
                        w_fin_d  = w_adv_fin;
                    end
                end else begin
                    w_cnt_d = r_cnt + c_cnt_w'(1);
                end
            end
            BUS_HOLD: begin
                if (w_phase_last) begin
                    w_state_d = BUS_GAP;
                    w_cs_n_d  = '1;
                    w_d_oe_d  = 1'b0;
                    w_a0_d    = 1'b1;
                    w_d_out_d = 8'h00;
                    w_rdbk_d  = 1'b0;
                    // second advance steps over a step the table marks unused
                    if (r_busy && !r_fin && w_tbl_skip) begin
                        w_pic_d  = w_adv_pic;
                        w_step_d = w_adv_step;
                        w_fin_d  = w_adv_fin;
                    end
                end else begin
                    w_cnt_d = r_cnt + c_cnt_w'(1);
                end
            end
            BUS_GAP: begin
                if (r_busy) begin
                    if (r_fin) begin
                        w_state_d = BUS_IDLE;
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                        w_pic_d   = 3'd0;
                        w_step_d  = STEP_ICW1;
                        w_fin_d   = 1'b0;
                    end else begin
                        w_load_init = 1'b1;
                    end
                end else begin
                    w_wr_ack_d = 1'b1;
                    if (r_pend || start) begin
                        w_start_take = 1'b1;
                    end else begin
                        w_state_d = BUS_IDLE;
                    end
                end
            end
            default: w_state_d = BUS_IDLE;
        endcase

        if (start && !r_busy && !w_start_take && (r_state != BUS_IDLE)) begin
            w_pend_d = 1'b1;
        end

        if (w_start_take) begin
            w_busy_d     = 1'b1;
            w_pend_d     = 1'b0;
            w_load_init  = 1'b1;
`ifdef PIC_INIT_READBACK_EN
            w_init_err_d = 1'b0;
`endif
        end

        if (w_load_init) begin
            w_state_d = BUS_SETUP;
            w_cnt_d   = '0;
            w_cs_n_d  = w_init_cs_n;
            w_a0_d    = w_tbl_a0;
            w_d_out_d = w_is_rdbk ? 8'h00 : w_tbl_data;
            w_d_oe_d  = !w_is_rdbk;
            w_rdbk_d  = w_is_rdbk;
        end

        if (w_load_rt) begin
            w_state_d = BUS_SETUP;
            w_cnt_d   = '0;
            w_cs_n_d  = w_rt_cs_n;
            w_a0_d    = wr_a0;
            w_d_out_d = wr_data;
            w_d_oe_d  = 1'b1;
            w_rdbk_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BUS_IDLE;
            r_cnt      <= '0;
            r_pic      <= 3'd0;
            r_step     <= STEP_ICW1;
            r_fin      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_wr_err   <= 1'b0;
            r_pend     <= 1'b0;
            r_rdbk     <= 1'b0;
            r_cs_n     <= '1;
            r_a0       <= 1'b1;
            r_wr_n     <= 1'b1;
            r_d_out    <= 8'h00;
            r_d_oe     <= 1'b0;
`ifdef PIC_INIT_READBACK_EN
            r_rd_n     <= 1'b1;
            r_init_err <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_pic      <= w_pic_d;
            r_step     <= w_step_d;
            r_fin      <= w_fin_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_wr_ack   <= w_wr_ack_d;
            r_wr_err   <= w_wr_err_d;
            r_pend     <= w_pend_d;
            r_rdbk     <= w_rdbk_d;
            r_cs_n     <= w_cs_n_d;
            r_a0       <= w_a0_d;
            r_wr_n     <= w_wr_n_d;
            r_d_out    <= w_d_out_d;
            r_d_oe     <= w_d_oe_d;
`ifdef PIC_INIT_READBACK_EN
            r_rd_n     <= w_rd_n_d;
            r_init_err <= w_init_err_d;
`endif
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign wr_ack = r_wr_ack;
    assign wr_err = r_wr_err;
    assign cs_n   = r_cs_n;
    assign a0     = r_a0;
    assign wr_n   = r_wr_n;
    assign d_out  = r_d_out;
    assign d_oe   = r_d_oe;
`ifdef PIC_INIT_READBACK_EN
    assign rd_n     = r_rd_n;
    assign init_err = r_init_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pic_cascade_init_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pic_cascade_init_sequencer : directed self-checking bench (7-PIC and 1-PIC)
// Revision                      : 1.0
// ============================================================================
module tb_pic_cascade_init_sequencer;

    logic       clk;
    logic       rst;
    logic       start, busy, done;
    logic       wr_req, wr_a0, wr_ack, wr_err;
    logic [2:0] wr_pic;
    logic [7:0] wr_data;
    logic [6:0] cs_n;
    logic       a0, wr_n, d_oe;
    logic [7:0] d_out;

    logic       start1, busy1, done1, wr_ack1, wr_err1;
    logic [0:0] cs_n1;
    logic       a0_1, wr_n1, d_oe1;
    logic [7:0] d_out1;
    logic       wr_req1 = 1'b0;
    logic [2:0] wr_pic1 = 3'd0;
    logic       wr_a0_1 = 1'b0;
    logic [7:0] wr_data1 = 8'h00;

    int checks   = 0;
    int failures = 0;

    pic_cascade_init_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .wr_req(wr_req), .wr_pic(wr_pic), .wr_a0(wr_a0), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err), .cs_n(cs_n), .a0(a0), .wr_n(wr_n),
        .d_out(d_out), .d_oe(d_oe)
    );

    pic_cascade_init_sequencer #(.NUM_PICS(1)) u_one (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .wr_req(wr_req1), .wr_pic(wr_pic1), .wr_a0(wr_a0_1), .wr_data(wr_data1),
        .wr_ack(wr_ack1), .wr_err(wr_err1), .cs_n(cs_n1), .a0(a0_1), .wr_n(wr_n1),
        .d_out(d_out1), .d_oe(d_oe1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus monitors: log every wr_n falling edge and audit strobe widths.
    logic [6:0] log_cs [0:127];
    logic       log_a0 [0:127];
    logic [7:0] log_d  [0:127];
    int         log_n = 0, low_run = 0, pulses = 0, widths_bad = 0, multi_low = 0;
    logic       prev_wr_n = 1'b1;
    logic [0:0] log1_cs [0:15];
    logic       log1_a0 [0:15];
    logic [7:0] log1_d  [0:15];
    int         log1_n = 0;
    logic       prev_wr_n1 = 1'b1;

    always @(negedge clk) begin
        if (!wr_n) begin
            if (prev_wr_n && log_n < 128) begin
                log_cs[log_n] = cs_n;
                log_a0[log_n] = a0;
                log_d[log_n]  = d_out;
                log_n++;
            end
            low_run++;
        end else if (low_run != 0) begin
            pulses++;
            if (low_run != 2) widths_bad++;
            low_run = 0;
        end
        prev_wr_n = wr_n;
        if ($countones(~cs_n) > 1) multi_low++;
        if (!wr_n1 && prev_wr_n1 && log1_n < 16) begin
            log1_cs[log1_n] = cs_n1;
            log1_a0[log1_n] = a0_1;
            log1_d[log1_n]  = d_out1;
            log1_n++;
        end
        prev_wr_n1 = wr_n1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cs_n"},  32'(cs_n),   32'h7F);
        check({tag, "_a0"},    32'(a0),     32'h1);
        check({tag, "_wr_n"},  32'(wr_n),   32'h1);
        check({tag, "_d_out"}, 32'(d_out),  32'h0);
        check({tag, "_d_oe"},  32'(d_oe),   32'h0);
        check({tag, "_busy"},  32'(busy),   32'h0);
        check({tag, "_done"},  32'(done),   32'h0);
        check({tag, "_ack"},   32'(wr_ack), 32'h0);
        check({tag, "_err"},   32'(wr_err), 32'h0);
    endtask

    int         n, k, base, pbase, bbase, busy_cnt, acked;
    logic [6:0] exp_cs;
    logic       exp_a0;
    logic [7:0] exp_d;

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        wr_req = 1'b0; wr_pic = 3'd0; wr_a0 = 1'b0; wr_data = 8'h00;
        repeat (3) tick();
        check_reset("reset");
        check("reset_one_cs_n", 32'(cs_n1), 32'h1);
        rst = 1'b0;
        tick();

        // Full init with a runtime request raised mid-sequence
        base = log_n; pbase = pulses; bbase = widths_bad;
        start = 1'b1; tick(); start = 1'b0;
        n = 1;
        check("first_setup", {busy, cs_n, a0, d_oe, wr_n, d_out}, {1'b1, 7'h7E, 1'b0, 1'b1, 1'b1, 8'h11});
        busy_cnt = 0; acked = 0;
        while (!done && n < 400) begin
            if (busy) busy_cnt++;
            if (wr_ack) acked++;
            if (n == 50) begin
                wr_req = 1'b1; wr_pic = 3'd0; wr_a0 = 1'b0; wr_data = 8'h20;
            end
            tick(); n++;
        end
        check("done_cycle", n, 176);
        check("busy_cycles", busy_cnt, 175);
        check("busy_at_done", 32'(busy), 32'h0);
        check("ack_during_init", acked, 0);
        check("init_writes", log_n - base, 35);
        check("init_pulses", pulses - pbase, 35);
        check("init_bad_width", widths_bad - bbase, 0);
        for (int p = 0; p < 7; p++) begin
            for (int s = 0; s < 5; s++) begin
                exp_cs = 7'h7F;
                exp_cs[p] = 1'b0;
                exp_a0 = (s != 0);
                case (s)
                    0:       exp_d = 8'h11;
                    1:       exp_d = 8'h08 + 8'(8 * p);
                    2:       exp_d = (p == 0) ? 8'h3F : 8'(p - 1);
                    3:       exp_d = (p == 0) ? 8'h00 : 8'h02;
                    default: exp_d = 8'h00;
                endcase
                check($sformatf("init_wr_p%0d_s%0d", p, s),
                      {log_cs[base + p*5 + s], log_a0[base + p*5 + s], log_d[base + p*5 + s]},
                      {exp_cs, exp_a0, exp_d});
            end
        end

        // Pending runtime write is accepted on the done cycle
        tick();
        k = 0;
        check("rt_setup", {cs_n, a0, d_oe, wr_n, d_out, busy}, {7'h7E, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0});
        while (!wr_ack && k < 20) begin
            tick(); k++;
        end
        check("rt_ack_latency", k, 5);
        check("rt_ack_err", 32'(wr_err), 32'h0);
        tick();
        wr_req = 1'b0;
        check("rt_no_reaccept", {cs_n, wr_ack}, {7'h7F, 1'b0});
        repeat (3) tick();
        check("rt_writes", log_n - base, 36);
        check("rt_logged", {log_cs[base + 35], log_a0[base + 35], log_d[base + 35]}, {7'h7E, 1'b0, 8'h20});

        // Invalid target PIC: immediate error ack, no bus activity
        pbase = pulses;
        wr_pic = 3'd7; wr_a0 = 1'b1; wr_data = 8'hAA; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        check("bad_pic_ack", {wr_ack, wr_err, cs_n, wr_n, d_oe}, {1'b1, 1'b1, 7'h7F, 1'b1, 1'b0});
        tick();
        check("bad_pic_after", {wr_ack, wr_err, cs_n}, {1'b0, 1'b0, 7'h7F});
        repeat (6) tick();
        check("bad_pic_no_pulse", pulses - pbase, 0);

        // Reset during the strobe of slave 2 ICW2, then restart
        start = 1'b1; tick(); start = 1'b0;
        repeat (56) tick();
        check("s2_icw2_strobe", {wr_n, cs_n, a0, d_out}, {1'b0, 7'h7B, 1'b1, 8'h18});
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        tick();
        base = log_n; pbase = pulses; bbase = widths_bad;
        start = 1'b1; tick(); start = 1'b0;
        n = 1;
        check("restart_setup", {busy, cs_n, a0, d_out}, {1'b1, 7'h7E, 1'b0, 8'h11});
        while (!done && n < 400) begin
            tick(); n++;
        end
        check("restart_done_cycle", n, 176);
        check("restart_writes", log_n - base, 35);
        check("restart_bad_width", widths_bad - bbase, 0);
        check("restart_s2_icw2", {log_cs[base + 11], log_d[base + 11]}, {7'h7B, 8'h18});
        check("cs_one_hot", multi_low, 0);

        // Single-PIC build: ICW1 in single mode, no ICW3
        base = log1_n;
        start1 = 1'b1; tick(); start1 = 1'b0;
        n = 1;
        while (!done1 && n < 100) begin
            tick(); n++;
        end
        check("one_done_cycle", n, 21);
        check("one_writes", log1_n - base, 4);
        check("one_icw1", {log1_cs[base], log1_a0[base], log1_d[base]}, {1'b0, 1'b0, 8'h13});
        check("one_icw2", {log1_cs[base + 1], log1_a0[base + 1], log1_d[base + 1]}, {1'b0, 1'b1, 8'h08});
        check("one_icw4", {log1_cs[base + 2], log1_a0[base + 2], log1_d[base + 2]}, {1'b0, 1'b1, 8'h00});
        check("one_ocw1", {log1_cs[base + 3], log1_a0[base + 3], log1_d[base + 3]}, {1'b0, 1'b1, 8'h00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pic_cascade_init_sequencer.md
Name: pic_cascade_init_sequencer

Overview:
- Bus-write controller that programs a master 8259-compatible PIC plus up to 6 cascaded slaves over the shared 8-bit data bus.
- After `start`, it walks the ICW1–ICW4 and OCW1 sequence for each PIC in index order (0 = master) and drives the per-PIC `cs_n`, `a0`, `wr_n` and data strobes.
- After init it services single runtime OCW writes from a requester through a req/ack handshake.
- It replaces hand-sequenced WR/CS/A0 toggling at system level.

Parameters:
- NUM_PICS, 7, total PICs (1 master + NUM_PICS-1 slaves); legal range 1..8.
- SETUP_CYC, 1, cycles `cs_n`/`a0`/data are valid before `wr_n` falls; ≥1.
- WR_LOW_CYC, 2, cycles `wr_n` is held low; ≥1.
- HOLD_CYC, 1, cycles `cs_n`/`a0`/data are held after `wr_n` rises; ≥1.
- VECTOR_BASE, 8'h08, ICW2 of PIC k = VECTOR_BASE + 8*k (mod 256).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins full init
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last init write completes
- wr_req  in  1  runtime write request; held until wr_ack
- wr_pic  in  3  target PIC index
- wr_a0  in  1  A0 for the runtime write
- wr_data  in  8  data for the runtime write
- wr_ack  out  1  one-cycle completion pulse
- wr_err  out  1  valid with wr_ack; 1 = wr_pic ≥ NUM_PICS, no bus cycle issued
- cs_n  out  NUM_PICS  per-PIC chip select, active low
- a0  out  1  shared address bit
- wr_n  out  1  shared write strobe, active low
- d_out  out  8  bus data
- d_oe  out  1  bus drive enable; the top level tristates D when low

Behaviour:
Reset values: `cs_n` all 1, `a0` 1, `wr_n` 1, `d_out` 0, `d_oe` 0, `busy` 0, `done` 0, `wr_ack` 0, `wr_err` 0. A reset mid-write returns to these values at the next edge; a partial write is abandoned.

Bus-cycle FSM (one write):
- IDLE → SETUP (SETUP_CYC) → STROBE (WR_LOW_CYC) → HOLD (HOLD_CYC) → GAP (1) → IDLE.
- In SETUP, STROBE and HOLD: the target `cs_n` bit is 0, `d_oe`=1, and `a0`/`d_out` are stable.
- `wr_n`=0 only in STROBE.
- In GAP: all `cs_n` are 1 and `d_oe`=0.
- Write length = SETUP_CYC + WR_LOW_CYC + HOLD_CYC + 1 cycles (default 5).
- At most one `cs_n` bit is low in any cycle.

Init sequence for each PIC k = 0..NUM_PICS-1, steps in order:
- ICW1: a0=0, data 8'h11 (edge, cascade, IC4).
- ICW2: a0=1, data VECTOR_BASE + 8k.
- ICW3: a0=1.
  - Master: data = mask with bits 0..NUM_PICS-2 set (8'h3F at default).
  - Slave k: data = k-1.
  - Skipped when NUM_PICS=1, and ICW1 is then 8'h13.
- ICW4: a0=1. Master 8'h00; slaves 8'h02 (AEOI).
- OCW1: a0=1, data 8'h00.

Sequencing:
- Writes are back-to-back with no idle beyond GAP.
- `done` pulses the cycle after the final GAP; `busy` falls on that same cycle.
- `start` while `busy` is ignored.
- `start` coinciding with an in-flight runtime write is latched and taken after that write's GAP.

Runtime writes:
- Accepted only in IDLE and not `busy`.
- Init has priority: a `wr_req` during init waits and is taken after `done`.
- Inputs are sampled on the acceptance cycle.
- `wr_ack` pulses the cycle after GAP.
- Invalid `wr_pic`: `wr_ack`=1 and `wr_err`=1 on the cycle after acceptance; no `cs_n` toggles.
- The requester must drop `wr_req` the cycle after `wr_ack`. A `wr_req` still high then is treated as a new request.

Optional Feature:
- Macro: `PIC_INIT_READBACK_EN`.
- When defined:
  - Adds ports `rd_n` (out 1, reset 1), `d_in` (in 8) and `init_err` (out 1, reset 0, sticky until rst/start).
  - After each PIC's OCW1, the sequencer runs a read cycle. Timing is the same as a write, with `rd_n` low in STROBE, `d_oe`=0 and a0=1.
  - `d_in` is sampled on the last STROBE cycle; a value ≠ 8'h00 sets `init_err`.
  - Each read adds 5 cycles per PIC.
- When undefined: these ports do not exist and there are no read cycles.

Decomposition:
- Package `pic_seq_pkg`:
  - step enum (ICW1, ICW2, ICW3, ICW4, OCW1, RDBK).
  - bus-FSM state enum (IDLE, SETUP, STROBE, HOLD, GAP).
  - constants ICW1_VAL=8'h11, ICW4_MASTER=8'h00, ICW4_SLAVE=8'h02, OCW1_VAL=8'h00.
- Sub-module `pic_init_table`: combinational (pic_idx, step) → {data, a0, skip}. The sequencer holds the step/PIC counters and the bus FSM.

Test Plan:
- Default params, `start` pulse → exactly 35 `wr_n` low pulses, each 2 cycles.
  - Master sees 11,08,3F,00,00 with a0 0,1,1,1,1.
  - Slave 3 sees 11,20,02,02,00.
  - `done` at cycle 176 after start; `busy` high 175 cycles.
- `wr_req` (pic=0, a0=0, data=8'h20) raised mid-init → held until after `done`, then one write with only `cs_n[0]` low; `wr_ack` 5 cycles after acceptance.
- `wr_req` with pic=7 at NUM_PICS=7 → `wr_ack`+`wr_err` next cycle; `cs_n`/`wr_n` unchanged.
- `rst` asserted in STROBE of slave 2 ICW2 → next edge all outputs at reset values; new `start` restarts from master ICW1.
- NUM_PICS=1 → ICW1=8'h13, no ICW3, 4 writes total.
- With `PIC_INIT_READBACK_EN`, `d_in` forced to 8'h04 during slave 5 readback → `init_err`=1; sequence still completes and `done` pulses.
